// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// 8N1 frames with optional even parity and error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic       i_rx_clk,
  input  logic       i_rx_rst,
  input  logic       i_rx_data_in,
  input  logic       i_parity_bit,
  output logic [7:0] o_rx_data_out,
  output logic       o_rx_data_valid,
  output logic       o_rx_busy,
  output logic       o_parity_err,
  output logic       o_frame_err
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(H - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [2:0]    I_LAST = 3'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic              r_sync1;
  logic              r_sync2;
  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_par_en;
  logic              r_perr;
  logic [7:0]        r_out;
  logic              r_valid;
  logic              r_perr_o;
  logic              r_ferr_o;

  logic w_rx;
  logic w_tick;
  logic w_mid;

  assign w_rx   = r_sync2;
  assign w_tick = (r_cnt == C_LAST);
  assign w_mid  = (r_cnt == C_HALF);

  always_ff @(posedge i_rx_clk or negedge i_rx_rst) begin
    if (!i_rx_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_par_en <= 1'b0;
      r_perr   <= 1'b0;
      r_out    <= 8'h00;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
    end else begin
      r_sync1 <= i_rx_data_in;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            // detect cycle already counts as the first low clock
            r_state  <= S_START;
            r_cnt    <= C_ONE;
            r_idx    <= '0;
            r_par_en <= i_parity_bit;
            r_perr   <= 1'b0;
          end
        end
        S_START: begin
          if (w_mid) begin
            r_cnt   <= '0;
            r_state <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_data <= {w_rx, r_data[DATA_W-1:1]};
            if (r_idx == I_LAST) begin
              r_idx   <= '0;
              r_state <= r_par_en ? S_PAR : S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_perr  <= w_rx ^ (^r_data);
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt    <= '0;
            r_out    <= 8'(r_data);
            r_valid  <= 1'b1;
            r_perr_o <= r_par_en & r_perr;
            r_ferr_o <= ~w_rx;
            // a low stop bit means break: hold off until line idles
            r_state  <= w_rx ? S_IDLE : S_WAIT;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_WAIT: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_data_out   = r_out;
  assign o_rx_data_valid = r_valid;
  assign o_rx_busy       = (r_state != S_IDLE);
  assign o_parity_err    = r_perr_o;
  assign o_frame_err     = r_ferr_o;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames against
// an expectation queue built from the frame format rules.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;

  logic       clk;
  logic       rst_n;
  logic       line;
  logic       pbit;
  logic [7:0] dout;
  logic       valid;
  logic       busy;
  logic       perr;
  logic       ferr;

  int n_chk;
  int n_err;
  int cyc;

  int         e_cyc[$];
  logic [7:0] e_dat[$];
  logic       e_pe[$];
  logic       e_fe[$];
  logic       e_bz[$];

  int         m_cyc[$];
  logic [7:0] m_dat[$];
  logic       m_pe[$];
  logic       m_fe[$];
  logic       m_bz[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .i_rx_clk       (clk),
    .i_rx_rst       (rst_n),
    .i_rx_data_in   (line),
    .i_parity_bit   (pbit),
    .o_rx_data_out  (dout),
    .o_rx_data_valid(valid),
    .o_rx_busy      (busy),
    .o_parity_err   (perr),
    .o_frame_err    (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      m_cyc.push_back(cyc);
      m_dat.push_back(dout);
      m_pe.push_back(perr);
      m_fe.push_back(ferr);
      m_bz.push_back(busy);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drives one frame starting just after a posedge; queues the expected result
  task automatic send(input logic [7:0] d, input logic pen,
                      input logic flip, input logic stop,
                      input int extra_low);
    logic b[$];
    int   n;
    int   k;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pen) b.push_back((^d) ^ flip);
    b.push_back(stop);
    k = pen ? 10 : 9;
    pbit = pen;
    n = cyc;
    e_cyc.push_back(n + 3 + H - 1 + k * CPB);
    e_dat.push_back(d);
    e_pe.push_back(pen & flip);
    e_fe.push_back(~stop);
    e_bz.push_back(~stop);
    foreach (b[i]) begin
      line = b[i];
      if (i == 5) pbit = ~pen;
      tick(CPB);
    end
    if (extra_low > 0) begin
      line = 1'b0;
      tick(extra_low);
      chk("break_busy", int'(busy), 1);
    end
    line = 1'b1;
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, m_cyc.size(), e_cyc.size());
    while (e_cyc.size() > 0 && m_cyc.size() > 0) begin
      chk({tag, "_cyc"}, m_cyc.pop_front(), e_cyc.pop_front());
      chk({tag, "_data"}, int'(m_dat.pop_front()), int'(e_dat.pop_front()));
      chk({tag, "_perr"}, int'(m_pe.pop_front()), int'(e_pe.pop_front()));
      chk({tag, "_ferr"}, int'(m_fe.pop_front()), int'(e_fe.pop_front()));
      chk({tag, "_busy"}, int'(m_bz.pop_front()), int'(e_bz.pop_front()));
    end
    e_cyc.delete(); e_dat.delete(); e_pe.delete();
    e_fe.delete(); e_bz.delete();
    m_cyc.delete(); m_dat.delete(); m_pe.delete();
    m_fe.delete(); m_bz.delete();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    line  = 1'b1;
    pbit  = 1'b0;
    rst_n = 1'b0;

    tick(5);
    chk("rst_data", int'(dout), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_perr", int'(perr), 0);
    chk("rst_ferr", int'(ferr), 0);
    rst_n = 1'b1;
    tick(50);
    chk("post_rst_busy", int'(busy), 0);
    check_q("idle");

    send(8'hAA, 1'b1, 1'b0, 1'b1, 0);
    tick(20);
    check_q("aa_good");

    send(8'hAA, 1'b1, 1'b1, 1'b1, 0);
    tick(5);
    send(8'h0F, 1'b0, 1'b0, 1'b1, 0);
    tick(20);
    check_q("perr_then_ok");

    send(8'h3C, 1'b0, 1'b0, 1'b0, 40);
    tick(6);
    chk("break_release_busy", int'(busy), 0);
    tick(40);
    check_q("break");

    line = 1'b0;
    tick(4);
    line = 1'b1;
    tick(2);
    chk("glitch_busy_hi", int'(busy), 1);
    tick(7);
    chk("glitch_busy_lo", int'(busy), 0);
    tick(40);
    check_q("glitch");

    // abort inside data bit 3 of a frame whose byte has ferr still set
    send(8'h81, 1'b0, 1'b0, 1'b0, 0);
    tick(20);
    check_q("pre_abort");
    line = 1'b0;
    tick(CPB);
    line = 1'b1;
    tick(3 * CPB);
    line = 1'b0;
    tick(8);
    rst_n = 1'b0;
    tick(2);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ferr", int'(ferr), 0);
    chk("abort_data", int'(dout), 0);
    line = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    send(8'h55, 1'b0, 1'b0, 1'b1, 0);
    tick(20);
    check_q("after_abort");

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 0);
      if (($urandom % 2) == 1) tick($urandom_range(1, 20));
    end
    tick(30);
    check_q("random");
    chk("end_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
